matmul_systolic_stream: RTL and testbench
=========================================

# matmul_systolic_stream

Parametrised output-stationary systolic matrix multiplier computing C[M×N] = A[M×K] · B[K×N] for streamed operands, and the successor to the fixed 4×4 MAC grid. It accepts one column of A and one row of B per beat and skews them internally, so upstream logic needs no diagonal alignment. It accumulates in an M×N grid of signed MAC cells and then drains C one row per handshake. It sits between the operand-fetch buffers and the result writeback in the accelerator datapath.

## Interface
- DATA_WIDTH, 8, operand width, signed two's complement
- ACC_WIDTH, 32, accumulator/result width; must be ≥ 2*DATA_WIDTH
- M, 4, rows of A and C (≥ 1)
- N, 4, columns of B and C (≥ 1)
- K, 4, inner dimension, i.e. beats per operation (≥ 1)

- i_clk  in  1  clock; all logic on the rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  begin an operation; honoured only in IDLE
- i_in_valid  in  1  operand beat present
- i_a_col  in  M*DATA_WIDTH  column k of A; element i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- i_b_row  in  N*DATA_WIDTH  row k of B; element j at bits [j*DATA_WIDTH +: DATA_WIDTH]
- o_in_ready  out  1  beat accepted when i_in_valid && o_in_ready
- i_c_ready  in  1  downstream accepts a C row
- o_c_valid  out  1  o_c_row/o_c_idx valid
- o_c_row  out  N*ACC_WIDTH  row o_c_idx of C; element j at [j*ACC_WIDTH +: ACC_WIDTH]
- o_c_idx  out  clog2(max(M,2))  row index 0..M-1
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse after the last row handshake

## Operation
- FSM: IDLE → LOAD → FLUSH → DRAIN → IDLE.
- IDLE: i_start=1 clears all accumulators, the beat counter and the flush counter, then moves to LOAD.
- LOAD:
  - o_in_ready=1.
  - Each accepted beat k (0..K-1) enters the skew stage. a_i is delayed i cycles and b_j is delayed j cycles, and each carries a valid tag.
  - After K accepted beats, move to FLUSH.
  - i_in_valid=0 inserts a bubble. Its tag is 0 and no cell accumulates it.
- PE(i,j):
  - Registers a→right, b→down and valid alongside the data.
  - When valid: acc += sign_extend(a*b), where the product is a signed 2*DATA_WIDTH value extended to ACC_WIDTH.
  - The sum wraps modulo 2^ACC_WIDTH; no saturation and no overflow flag.
- FLUSH: counts exactly M+N-1 cycles so PE(M-1,N-1) absorbs the last beat, then moves to DRAIN. No beats are accepted.
- DRAIN:
  - o_c_valid=1 and o_c_row = acc row o_c_idx, with o_c_idx starting at 0.
  - On i_c_ready, o_c_idx increments.
  - After the handshake on row M-1, o_done pulses and the FSM returns to IDLE.
  - Output stays stable while i_c_ready=0.
- Ignored inputs: i_start outside IDLE; i_in_valid outside LOAD (no effect, no error).
- i_rst in any state, including mid-LOAD or mid-DRAIN, takes effect on the next edge. It returns the FSM to IDLE, clears skew registers, valid tags, counters and accumulators, and discards any partial result.

## Timing
- Reset values: o_in_ready=0, o_c_valid=0, o_c_row=0, o_c_idx=0, o_busy=0, o_done=0.
- i_start is sampled at edge t0. o_busy and o_in_ready are high from t0+1.
- With the last beat accepted at edge tL, FLUSH occupies tL+1 .. tL+M+N-1.
- o_c_valid rises at tL+M+N.
- Full-rate latency, start to first row: K+M+N cycles. Start to o_done with i_c_ready held high: K+M+N+M cycles.
- o_done is asserted in the cycle after the final row handshake, together with the IDLE state (o_busy=0).
- i_start may be asserted in the same cycle as o_done and is honoured.
- o_c_row is registered; no combinational path from any input to any output.

## Test plan
- Identity: M=N=K=4, A=I, B[k][j]=4k+j+1, full-rate beats and i_c_ready=1 → rows 0..3 = {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}; first o_c_valid exactly 12 cycles after start.
- Signed extremes: all A=B=-128, K=4, ACC_WIDTH=32 → every element 65536. Then A=-128, B=127 → every element -65024.
- Bubbles: same operands as the identity test with i_in_valid toggling 1,0,1,0… → identical C; o_c_valid delayed by exactly the number of bubble cycles.
- Backpressure: i_c_ready low for 3 cycles on each row → o_c_row/o_c_idx held stable; exactly 4 handshakes; one o_done pulse.
- Reset and ignored start: i_rst after 2 beats returns all outputs to reset values; a fresh operation then gives a correct C with no residue. A second i_start during FLUSH is ignored.
- Wrap: ACC_WIDTH=16, A=B=127, K=5 → elements 80645 mod 65536 = 15109.

Source files
------------

// File: rtl/matmul_systolic_stream_if.sv
// matmul_systolic_stream_if: operand-in / result-out handshake bundle for the systolic multiplier
interface matmul_systolic_stream_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int M          = 4,
    parameter int N          = 4
);
    localparam int IW = $clog2(M > 1 ? M : 2);
    logic                    i_start;
    logic                    i_in_valid;
    logic [M*DATA_WIDTH-1:0] i_a_col;
    logic [N*DATA_WIDTH-1:0] i_b_row;
    logic                    o_in_ready;
    logic                    i_c_ready;
    logic                    o_c_valid;
    logic [N*ACC_WIDTH-1:0]  o_c_row;
    logic [IW-1:0]           o_c_idx;
    logic                    o_busy;
    logic                    o_done;
    modport master (
        output i_start, i_in_valid, i_a_col, i_b_row, i_c_ready,
        input  o_in_ready, o_c_valid, o_c_row, o_c_idx, o_busy, o_done
    );
    modport slave (
        input  i_start, i_in_valid, i_a_col, i_b_row, i_c_ready,
        output o_in_ready, o_c_valid, o_c_row, o_c_idx, o_busy, o_done
    );
endinterface

// File: rtl/matmul_systolic_stream.sv
// matmul_systolic_stream: output-stationary MxN systolic GEMM with internal operand skew and row-wise drain
module matmul_systolic_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int M          = 4,
    parameter int N          = 4,
    parameter int K          = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    matmul_systolic_stream_if.slave   bus
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int IW = $clog2(M > 1 ? M : 2);
    localparam int BW = $clog2(K + 1);
    localparam int FW = $clog2(M + N);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]      r_state;
    logic [BW-1:0]   r_beat;
    logic [FW-1:0]   r_flush;
    logic [IW-1:0]   r_idx;
    logic [N*AW-1:0] r_row;
    logic            r_done;
    logic            w_clr;
    logic            w_beat;
    logic            w_hs;
    logic [N*AW-1:0] w_accrow [M];
    logic [DW-1:0]   w_a  [M][N+1];
    logic            w_va [M][N+1];
    logic [DW-1:0]   w_b  [M+1][N];
    logic            w_vb [M+1][N];

    assign w_clr  = r_state == S_IDLE && bus.i_start;
    assign w_beat = r_state == S_LOAD && bus.i_in_valid;
    assign w_hs   = r_state == S_DRAIN && bus.i_c_ready;

    assign bus.o_in_ready = r_state == S_LOAD;
    assign bus.o_busy     = r_state != S_IDLE;
    assign bus.o_c_valid  = r_state == S_DRAIN;
    assign bus.o_c_row    = r_row;
    assign bus.o_c_idx    = r_idx;
    assign bus.o_done     = r_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_flush <= '0;
            r_idx   <= '0;
            r_row   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_hs && r_idx == IW'(M - 1);
            case (r_state)
                S_IDLE: if (bus.i_start) begin
                    r_state <= S_LOAD;
                    r_beat  <= '0;
                    r_flush <= '0;
                end
                S_LOAD: if (w_beat) begin
                    r_beat <= r_beat + 1'b1;
                    if (r_beat == BW'(K - 1)) r_state <= S_FLUSH;
                end
                // One spare cycle past the far corner's last MAC lets row 0 be registered on entry
                S_FLUSH: if (r_flush == FW'(M + N - 1)) begin
                    r_state <= S_DRAIN;
                    r_idx   <= '0;
                    r_row   <= w_accrow[0];
                end else begin
                    r_flush <= r_flush + 1'b1;
                end
                default: if (bus.i_c_ready) begin
                    if (r_idx == IW'(M - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                        r_row <= w_accrow[IW'(r_idx + 1'b1)];
                    end
                end
            endcase
        end
    end

    for (genvar i = 0; i < M; i++) begin : g_askew
        if (i == 0) begin : g_z
            assign w_a[0][0]  = bus.i_a_col[0 +: DW];
            assign w_va[0][0] = w_beat;
        end else begin : g_d
            logic [DW-1:0] r_d [i];
            logic          r_v [i];
            always_ff @(posedge i_clk) begin
                if (i_rst || w_clr) begin
                    for (int s = 0; s < i; s++) begin
                        r_d[s] <= '0;
                        r_v[s] <= 1'b0;
                    end
                end else begin
                    r_d[0] <= bus.i_a_col[i*DW +: DW];
                    r_v[0] <= w_beat;
                    for (int s = 1; s < i; s++) begin
                        r_d[s] <= r_d[s-1];
                        r_v[s] <= r_v[s-1];
                    end
                end
            end
            assign w_a[i][0]  = r_d[i-1];
            assign w_va[i][0] = r_v[i-1];
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_bskew
        if (j == 0) begin : g_z
            assign w_b[0][0]  = bus.i_b_row[0 +: DW];
            assign w_vb[0][0] = w_beat;
        end else begin : g_d
            logic [DW-1:0] r_d [j];
            logic          r_v [j];
            always_ff @(posedge i_clk) begin
                if (i_rst || w_clr) begin
                    for (int s = 0; s < j; s++) begin
                        r_d[s] <= '0;
                        r_v[s] <= 1'b0;
                    end
                end else begin
                    r_d[0] <= bus.i_b_row[j*DW +: DW];
                    r_v[0] <= w_beat;
                    for (int s = 1; s < j; s++) begin
                        r_d[s] <= r_d[s-1];
                        r_v[s] <= r_v[s-1];
                    end
                end
            end
            assign w_b[0][j]  = r_d[j-1];
            assign w_vb[0][j] = r_v[j-1];
        end
    end

    for (genvar i = 0; i < M; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_pe
            logic [DW-1:0]          r_a;
            logic [DW-1:0]          r_b;
            logic                   r_va;
            logic                   r_vb;
            logic signed [AW-1:0]   r_acc;
            logic signed [2*DW-1:0] w_p;
            assign w_p = $signed(w_a[i][j]) * $signed(w_b[i][j]);
            always_ff @(posedge i_clk) begin
                if (i_rst || w_clr) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_va  <= 1'b0;
                    r_vb  <= 1'b0;
                    r_acc <= '0;
                end else begin
                    r_a  <= w_a[i][j];
                    r_b  <= w_b[i][j];
                    r_va <= w_va[i][j];
                    r_vb <= w_vb[i][j];
                    if (w_va[i][j] && w_vb[i][j]) r_acc <= r_acc + AW'(w_p);
                end
            end
            assign w_a[i][j+1]  = r_a;
            assign w_va[i][j+1] = r_va;
            assign w_b[i+1][j]  = r_b;
            assign w_vb[i+1][j] = r_vb;
            assign w_accrow[i][j*AW +: AW] = r_acc;
        end
    end
endmodule

// File: tb/tb_matmul_systolic_stream.sv
// tb_matmul_systolic_stream: directed table-driven checks of the systolic multiplier
module tb_matmul_systolic_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;

    matmul_systolic_stream_if #(.DATA_WIDTH(8), .ACC_WIDTH(32), .M(4), .N(4)) b4();
    matmul_systolic_stream #(.DATA_WIDTH(8), .ACC_WIDTH(32), .M(4), .N(4), .K(4)) dut (
        .i_clk(clk), .i_rst(rst), .bus(b4));
    matmul_systolic_stream_if #(.DATA_WIDTH(8), .ACC_WIDTH(16), .M(2), .N(2)) bw();
    matmul_systolic_stream #(.DATA_WIDTH(8), .ACC_WIDTH(16), .M(2), .N(2), .K(5)) dutw (
        .i_clk(clk), .i_rst(rst), .bus(bw));

    typedef struct packed {
        logic [3:0][3:0][7:0]  a;
        logic [3:0][3:0][7:0]  b;
        logic [3:0][3:0][31:0] c;
        logic                  bub;
        logic [1:0]            stall;
        logic                  junk;
    } vec_t;
    vec_t tv [6];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input int v, input bit pre, input bit chain);
        int cnt;
        int lat;
        int k;
        int bub;
        if (!pre) begin
            @(negedge clk);
            b4.i_start = 1'b1;
        end
        cnt = 0;
        @(negedge clk);
        cnt++;
        b4.i_start = 1'b0;
        chk($sformatf("v%0d busy", v), b4.o_busy, 1);
        chk($sformatf("v%0d in_ready", v), b4.o_in_ready, 1);
        chk($sformatf("v%0d done_low", v), b4.o_done, 0);
        k = 0;
        bub = 0;
        while (k < 4) begin
            if (tv[v].bub && cnt % 2 == 0) begin
                b4.i_in_valid = 1'b0;
                bub++;
            end else begin
                b4.i_in_valid = 1'b1;
                for (int i = 0; i < 4; i++) b4.i_a_col[i*8 +: 8] = tv[v].a[i][k];
                for (int j = 0; j < 4; j++) b4.i_b_row[j*8 +: 8] = tv[v].b[k][j];
                k++;
            end
            @(negedge clk);
            cnt++;
        end
        chk($sformatf("v%0d flush_not_ready", v), b4.o_in_ready, 0);
        b4.i_in_valid = tv[v].junk;
        b4.i_start    = tv[v].junk;
        if (tv[v].junk) begin
            b4.i_a_col = {4{8'h55}};
            b4.i_b_row = {4{8'h55}};
        end
        while (!b4.o_c_valid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        b4.i_start    = 1'b0;
        b4.i_in_valid = 1'b0;
        lat = cnt - 1;
        chk($sformatf("v%0d latency", v), lat, 12 + bub);
        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s < int'(tv[v].stall); s++) begin
                b4.i_c_ready = 1'b0;
                chk($sformatf("v%0d hold_idx%0d", v, r), b4.o_c_idx, r);
                chk($sformatf("v%0d hold_row%0d", v, r), b4.o_c_row, tv[v].c[r]);
                @(negedge clk);
                cnt++;
            end
            chk($sformatf("v%0d valid%0d", v, r), b4.o_c_valid, 1);
            chk($sformatf("v%0d idx%0d", v, r), b4.o_c_idx, r);
            chk($sformatf("v%0d row%0d", v, r), b4.o_c_row, tv[v].c[r]);
            b4.i_c_ready = 1'b1;
            @(negedge clk);
            cnt++;
        end
        b4.i_c_ready = 1'b0;
        chk($sformatf("v%0d done", v), b4.o_done, 1);
        chk($sformatf("v%0d idle_busy", v), b4.o_busy, 0);
        chk($sformatf("v%0d idle_valid", v), b4.o_c_valid, 0);
        chk($sformatf("v%0d done_time", v), cnt - 1, lat + 4 + 4 * int'(tv[v].stall));
        if (chain) begin
            b4.i_start = 1'b1;
        end else begin
            @(negedge clk);
            chk($sformatf("v%0d done_pulse", v), b4.o_done, 0);
        end
    endtask

    initial begin
        int cnt;
        {b4.i_start, b4.i_in_valid, b4.i_a_col, b4.i_b_row, b4.i_c_ready} = '0;
        {bw.i_start, bw.i_in_valid, bw.i_a_col, bw.i_b_row, bw.i_c_ready} = '0;
        for (int v = 0; v < 6; v++) tv[v] = '0;
        for (int i = 0; i < 4; i++) begin
            tv[0].a[i][i] = 8'd1;
            for (int j = 0; j < 4; j++) begin
                tv[0].b[i][j] = 8'(4 * i + j + 1);
                tv[0].c[i][j] = 32'(4 * i + j + 1);
            end
        end
        tv[1].a = {16{8'h80}};
        tv[1].b = {16{8'h80}};
        tv[1].c = {16{32'd65536}};
        tv[1].junk = 1'b1;
        tv[2].a = {16{8'h80}};
        tv[2].b = {16{8'h7f}};
        tv[2].c = {16{-32'sd65024}};
        tv[3] = tv[0];
        tv[3].bub = 1'b1;
        tv[4] = tv[0];
        tv[4].stall = 2'd3;
        tv[5].b = tv[0].b;
        tv[5].a[0][0] = 8'd2;
        tv[5].a[1][1] = 8'hff;
        tv[5].a[2][2] = 8'd3;
        tv[5].a[3][3] = 8'd4;
        tv[5].c[0] = {32'd8, 32'd6, 32'd4, 32'd2};
        tv[5].c[1] = {-32'sd8, -32'sd7, -32'sd6, -32'sd5};
        tv[5].c[2] = {32'd36, 32'd33, 32'd30, 32'd27};
        tv[5].c[3] = {32'd64, 32'd60, 32'd56, 32'd52};

        repeat (2) @(negedge clk);
        chk("rst in_ready", b4.o_in_ready, 0);
        chk("rst busy", b4.o_busy, 0);
        chk("rst c_valid", b4.o_c_valid, 0);
        chk("rst c_row", b4.o_c_row, 0);
        chk("rst c_idx", b4.o_c_idx, 0);
        chk("rst done", b4.o_done, 0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) run_op(v, 1'b0, 1'b0);

        @(negedge clk);
        b4.i_start = 1'b1;
        @(negedge clk);
        b4.i_start    = 1'b0;
        b4.i_in_valid = 1'b1;
        b4.i_a_col    = {4{8'd100}};
        b4.i_b_row    = {4{8'd100}};
        repeat (2) @(negedge clk);
        b4.i_in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst in_ready", b4.o_in_ready, 0);
        chk("midrst busy", b4.o_busy, 0);
        chk("midrst c_valid", b4.o_c_valid, 0);
        chk("midrst c_row", b4.o_c_row, 0);
        chk("midrst c_idx", b4.o_c_idx, 0);
        chk("midrst done", b4.o_done, 0);
        run_op(0, 1'b0, 1'b1);
        run_op(5, 1'b1, 1'b0);

        @(negedge clk);
        bw.i_start = 1'b1;
        @(negedge clk);
        bw.i_start = 1'b0;
        cnt = 1;
        repeat (5) begin
            bw.i_in_valid = 1'b1;
            bw.i_a_col    = {2{8'd127}};
            bw.i_b_row    = {2{8'd127}};
            @(negedge clk);
            cnt++;
        end
        bw.i_in_valid = 1'b0;
        while (!bw.o_c_valid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("wrap latency", cnt - 1, 9);
        chk("wrap row0", bw.o_c_row, {16'd15109, 16'd15109});
        bw.i_c_ready = 1'b1;
        @(negedge clk);
        chk("wrap idx1", bw.o_c_idx, 1);
        chk("wrap row1", bw.o_c_row, {16'd15109, 16'd15109});
        @(negedge clk);
        bw.i_c_ready = 1'b0;
        chk("wrap done", bw.o_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
